btn_event: RTL and testbench

Button event decoder placed directly downstream of the debouncer. It consumes the debounced `clean_btn` level and turns it into single-cycle event pulses for the clock/alarm setting logic:
- press, short press and release;
- long press, plus auto-repeat while the button stays held.

All timing is counted in `clk` cycles of the same fast clock that drives the debouncer.

---
 rtl/btn_event.sv | 149 ++++++++++++++
 tb/tb_btn_event.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/btn_event.sv
// Button event decoder: turns the debounced button level into press/short/long/repeat/release
// pulses plus a held level. Define BTN_EVENT_REPEAT_EN to build the auto-repeat logic.
module btn_event #(
    parameter int unsigned LONG_TICKS   = 2000,
    parameter int unsigned REPEAT_TICKS = 250,
    parameter int unsigned CNT_W        = 12
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clean_btn_i,
    output logic press_o,
    output logic short_press_o,
    output logic long_press_o,
    output logic repeat_o,
    output logic release_o,
    output logic held_o
);

    localparam logic [1:0] StWaitRel = 2'd0;
    localparam logic [1:0] StIdle    = 2'd1;
    localparam logic [1:0] StPressed = 2'd2;
    localparam logic [1:0] StLong    = 2'd3;

    localparam logic [CNT_W-1:0] HoldLast = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] CntMax   = '1;

    localparam bit ParamsOk = (LONG_TICKS >= 2) && (REPEAT_TICKS >= 1) &&
                              (LONG_TICKS < (2 ** CNT_W)) && (REPEAT_TICKS < (2 ** CNT_W));

    if (!ParamsOk) begin : gen_param_err
        $error("btn_event: illegal LONG_TICKS/REPEAT_TICKS/CNT_W combination");
    end

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             press_q, press_d;
    logic             short_press_q, short_press_d;
    logic             long_press_q, long_press_d;
    logic             repeat_q, repeat_d;
    logic             release_q, release_d;
    logic             held_q, held_d;

`ifdef BTN_EVENT_REPEAT_EN
    localparam logic [CNT_W-1:0] RepLast = CNT_W'(REPEAT_TICKS - 1);
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
`endif

    always_comb begin
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        press_d       = 1'b0;
        short_press_d = 1'b0;
        long_press_d  = 1'b0;
        repeat_d      = 1'b0;
        release_d     = 1'b0;
`ifdef BTN_EVENT_REPEAT_EN
        rep_cnt_d     = rep_cnt_q;
`endif
        case (state_q)
            StWaitRel: begin
                // A button held through reset must be released before it can generate events.
                if (!clean_btn_i) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (clean_btn_i) begin
                    state_d    = StPressed;
                    press_d    = 1'b1;
                    hold_cnt_d = CNT_W'(1);
                end
            end
            StPressed: begin
                if (clean_btn_i) begin
                    if (hold_cnt_q == HoldLast) begin
                        state_d      = StLong;
                        long_press_d = 1'b1;
`ifdef BTN_EVENT_REPEAT_EN
                        rep_cnt_d    = '0;
`endif
                    end else if (hold_cnt_q != CntMax) begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end else begin
                    state_d       = StIdle;
                    short_press_d = 1'b1;
                    release_d     = 1'b1;
                end
            end
            StLong: begin
                if (clean_btn_i) begin
`ifdef BTN_EVENT_REPEAT_EN
                    if (rep_cnt_q == RepLast) begin
                        repeat_d  = 1'b1;
                        rep_cnt_d = '0;
                    end else if (rep_cnt_q != CntMax) begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
`endif
                end else begin
                    state_d   = StIdle;
                    release_d = 1'b1;
                end
            end
            default: state_d = StWaitRel;
        endcase
        held_d = (state_d == StPressed) || (state_d == StLong);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StWaitRel;
            hold_cnt_q    <= '0;
            press_q       <= 1'b0;
            short_press_q <= 1'b0;
            long_press_q  <= 1'b0;
            repeat_q      <= 1'b0;
            release_q     <= 1'b0;
            held_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            press_q       <= press_d;
            short_press_q <= short_press_d;
            long_press_q  <= long_press_d;
            repeat_q      <= repeat_d;
            release_q     <= release_d;
            held_q        <= held_d;
        end
    end

`ifdef BTN_EVENT_REPEAT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rep_cnt_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
        end
    end
`endif

    assign press_o       = press_q;
    assign short_press_o = short_press_q;
    assign long_press_o  = long_press_q;
    assign repeat_o      = repeat_q;
    assign release_o     = release_q;
    assign held_o        = held_q;

endmodule

// File: tb/tb_btn_event.sv
// Self-checking bench for btn_event: directed scenarios plus random hold/release patterns,
// compared every cycle against a run-length model of the button.
module tb_btn_event;

    localparam int unsigned LongTicks = 8;
    localparam int unsigned RepTicks  = 4;
`ifdef BTN_EVENT_REPEAT_EN
    localparam bit RepEn = 1'b1;
`else
    localparam bit RepEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic clean_btn;
    logic press, short_press, long_press, rep, rel, held;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    string phase   = "reset";

    // Model state: armed once a low sample has been seen since reset; run counts high samples.
    bit armed = 1'b0;
    int run   = 0;

    always #5 clk = ~clk;

    btn_event #(
        .LONG_TICKS  (LongTicks),
        .REPEAT_TICKS(RepTicks),
        .CNT_W       (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .clean_btn_i  (clean_btn),
        .press_o      (press),
        .short_press_o(short_press),
        .long_press_o (long_press),
        .repeat_o     (rep),
        .release_o    (rel),
        .held_o       (held)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Output vector order: press, short_press, long_press, repeat, release, held.
    task automatic step(input logic b, input logic r);
        logic [5:0] exp;
        logic [5:0] got;
        clean_btn = b;
        rst       = r;
        @(posedge clk);
        cyc++;
        exp = '0;
        if (r) begin
            armed = 1'b0;
            run   = 0;
        end else if (!armed) begin
            if (!b) armed = 1'b1;
        end else if (b) begin
            run++;
            exp[5] = (run == 1);
            exp[3] = (run == int'(LongTicks));
            exp[2] = RepEn && (run > int'(LongTicks)) &&
                     (((run - int'(LongTicks)) % int'(RepTicks)) == 0);
            exp[0] = 1'b1;
        end else begin
            if (run > 0) begin
                exp[1] = 1'b1;
                exp[4] = (run < int'(LongTicks));
            end
            run = 0;
        end
        #1;
        got = {press, short_press, long_press, rep, rel, held};
        check_eq(phase, 32'(got), 32'(exp));
        check_eq("excl", 32'($countones({press, short_press, long_press, rep}) <= 1), 32'd1);
    endtask

    task automatic hold(input logic b, input int n);
        for (int i = 0; i < n; i++) step(b, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        clean_btn = 1'b0;

        phase = "reset";
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);

        phase = "short3";
        hold(1'b0, 3);
        hold(1'b1, 3);
        hold(1'b0, 2);

        phase = "long20";
        hold(1'b1, 20);
        hold(1'b0, 2);

        phase = "hold7";
        hold(1'b1, 7);
        hold(1'b0, 2);

        phase = "hold8";
        hold(1'b1, 8);
        hold(1'b0, 2);

        phase = "rst_held";
        step(1'b1, 1'b1);
        hold(1'b1, 10);
        hold(1'b0, 1);
        hold(1'b1, 3);
        hold(1'b0, 2);

        phase = "rst_long";
        hold(1'b1, 16);
        step(1'b1, 1'b1);
        hold(1'b1, 2);
        hold(1'b0, 2);

        phase = "b2b";
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        hold(1'b0, 2);

        phase = "random";
        for (int s = 0; s < 250; s++) begin
            if ($urandom_range(0, 19) == 0) begin
                step(1'($urandom_range(0, 1)), 1'b1);
            end else begin
                hold(1'(s % 2), int'($urandom_range(1, 14)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
